// File: rtl/bp_pkg.sv
// bp_pkg: shared counter encodings, BTB entry type and saturating-counter helper for the branch predictor
package bp_pkg;

    localparam int CNT_MAX_W  = 8;
    localparam int ADDR_MAX_W = 32;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_MAX_W-1:0] tag;
        logic [ADDR_MAX_W-1:0] target;
    } btb_entry_t;

    function automatic logic [CNT_MAX_W-1:0] sat_next(
        input logic [CNT_MAX_W-1:0] cnt,
        input logic                 taken,
        input int                   width
    );
        logic [CNT_MAX_W-1:0] max_v;
        max_v = CNT_MAX_W'((1 << width) - 1);
        if (taken) return (cnt == max_v) ? cnt : cnt + CNT_MAX_W'(1);
        return (cnt == '0) ? cnt : cnt - CNT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/bp_pht.sv
// bp_pht: pattern history table of saturating counters, one combinational read port and one write port
module bp_pht
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [CNT_W-1:0] rd_cnt_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    localparam logic [CNT_W-1:0] RST_CNT = CNT_W'((1 << (CNT_W - 1)) - 1);

    logic [CNT_W-1:0] cnt_q [ENTRIES];
    logic [CNT_W-1:0] wr_cnt_d;

    assign rd_cnt_o = cnt_q[rd_idx_i];
    assign wr_cnt_d = CNT_W'(sat_next(CNT_MAX_W'(cnt_q[wr_idx_i]), wr_taken_i, CNT_W));

    // Counters start weakly not-taken; flush restores that, otherwise train the written entry
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= RST_CNT;
        end else if (flush_i) begin
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= RST_CNT;
        end else if (wr_en_i) begin
            cnt_q[wr_idx_i] <= wr_cnt_d;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB plus PHT next-PC predictor; define BP_GSHARE_EN for gshare indexing, else bimodal
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 2,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = ADDR_W - IDX_W - 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_next_pc_o,
    output logic [IDX_W-1:0]  pred_ghr_o,
    input  logic              update_valid_i,
    input  logic [ADDR_W-1:0] update_pc_i,
    input  logic              update_taken_i,
    input  logic [ADDR_W-1:0] update_target_i,
    input  logic [IDX_W-1:0]  update_ghr_i
);

    btb_entry_t       btb_q [ENTRIES];
    btb_entry_t       lk_entry;
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [TAG_W-1:0] up_tag;
    logic [IDX_W-1:0] pht_rd_idx;
    logic [IDX_W-1:0] pht_wr_idx;
    logic [CNT_W-1:0] pht_cnt;
    logic             unused_bits;

    assign lk_idx   = lookup_pc_i[IDX_W+1:2];
    assign up_idx   = update_pc_i[IDX_W+1:2];
    assign lk_tag   = lookup_pc_i[ADDR_W-1:IDX_W+2];
    assign up_tag   = update_pc_i[ADDR_W-1:IDX_W+2];
    assign lk_entry = btb_q[lk_idx];

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;

    assign pht_rd_idx  = lk_idx ^ ghr_q;
    assign pht_wr_idx  = up_idx ^ update_ghr_i;
    assign pred_ghr_o  = ghr_q;
    assign unused_bits = ^{lookup_pc_i[1:0], update_pc_i[1:0]};

    // Global history shifts in every resolved outcome
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) ghr_q <= '0;
        else if (flush_i) ghr_q <= '0;
        else if (update_valid_i) ghr_q <= {ghr_q[IDX_W-2:0], update_taken_i};
    end
`else
    assign pht_rd_idx  = lk_idx;
    assign pht_wr_idx  = up_idx;
    assign pred_ghr_o  = '0;
    assign unused_bits = ^{lookup_pc_i[1:0], update_pc_i[1:0], update_ghr_i};
`endif

    bp_pht #(
        .ENTRIES (ENTRIES),
        .CNT_W   (CNT_W),
        .IDX_W   (IDX_W)
    ) u_pht (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .rd_idx_i   (pht_rd_idx),
        .rd_cnt_o   (pht_cnt),
        .wr_en_i    (update_valid_i),
        .wr_idx_i   (pht_wr_idx),
        .wr_taken_i (update_taken_i)
    );

    // Prediction is purely combinational from the pre-edge state; no update bypass
    always_comb begin
        pred_hit_o     = lk_entry.valid && (lk_entry.tag == ADDR_MAX_W'(lk_tag));
        pred_taken_o   = pred_hit_o && pht_cnt[CNT_W-1];
        pred_next_pc_o = pred_taken_o ? ADDR_W'(lk_entry.target) : lookup_pc_i + ADDR_W'(4);
    end

    // Only taken branches allocate; an alias at the same index is simply overwritten
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < ENTRIES; i++) btb_q[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < ENTRIES; i++) btb_q[i] <= '0;
        end else if (update_valid_i && update_taken_i) begin
            btb_q[up_idx] <= '{valid: 1'b1, tag: ADDR_MAX_W'(up_tag), target: ADDR_MAX_W'(update_target_i)};
        end
    end

endmodule
